// File: rtl/mem_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank_scheduler
// Purpose  : Arbitrates two requesters (port 0 = CPU load/store unit,
//            port 1 = program/data loader) for a three-bank data memory.
//            Handles one access at a time through an IDLE/ISSUE/WAIT/RESP
//            FSM. All bank control signals are registered, so they are
//            glitch-free.
// Ports    : clk, rst_n (async, active low)
//            req/we/addr/wdata 0|1 : requester inputs
//            gnt0/gnt1             : 1-cycle accept pulse (ISSUE cycle)
//            done0/done1           : 1-cycle completion pulse (RESP cycle)
//            rdata                 : data of the last successful read
//            err                   : invalid bank (index 2'b11), shown with done
//            bank_sel/en/we/addr/wdata : registered bank-side control
//            bank_rdata0..2        : bank read data
// Options  : MEM_SCHED_FIXED_PRIO_EN - port 0 always wins a tie (no
//            round-robin pointer). Round-robin is used when it is undefined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bank_scheduler #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1    // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [1:0]        bank_sel,
  output logic [2:0]        bank_en,
  output logic              bank_we,
  output logic [ADDR_W-3:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata0,
  input  logic [DATA_W-1:0] bank_rdata1,
  input  logic [DATA_W-1:0] bank_rdata2
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // WAIT lasts READ_LAT cycles: the counter is loaded with READ_LAT-1 and
  // the read data is captured on the edge where it reaches zero.
  localparam logic [1:0] LAT_M1  = 2'(READ_LAT - 1);

  logic [1:0]        state;
  logic [1:0]        lat_cnt;
  logic              lat_we;     // latched write flag of the current access
  logic              owner;      // 0: port 0 owns the access, 1: port 1

  logic              win1;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic [1:0]        pick_bank;
  logic [2:0]        pick_en;
  logic [DATA_W-1:0] rd_mux;

`ifdef MEM_SCHED_FIXED_PRIO_EN
  // Port 0 has strict priority.
  always_comb begin
    win1 = req1 & ~req0;
  end
`else
  // last = port that won the previous grant. The other port wins a tie.
  logic last;

  always_comb begin
    win1 = req1 & (~req0 | ~last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (state == S_IDLE && (req0 || req1)) begin
      last <= win1;
    end
  end
`endif

  always_comb begin
    pick_we    = win1 ? we1    : we0;
    pick_addr  = win1 ? addr1  : addr0;
    pick_wdata = win1 ? wdata1 : wdata0;
    pick_bank  = pick_addr[ADDR_W-1:ADDR_W-2];
    // Index 3 decodes to no enable, so bank_en can never be multi-hot.
    pick_en    = 3'b000;
    case (pick_bank)
      2'd0:    pick_en = 3'b001;
      2'd1:    pick_en = 3'b010;
      2'd2:    pick_en = 3'b100;
      default: pick_en = 3'b000;
    endcase
  end

  always_comb begin
    case (bank_sel)
      2'd0:    rd_mux = bank_rdata0;
      2'd1:    rd_mux = bank_rdata1;
      default: rd_mux = bank_rdata2;  // index 3 never reaches WAIT
    endcase
  end

  // Every output is registered. The values for the next cycle are
  // written on the edge that enters that cycle's state. gnt/done/err/
  // bank_en/bank_we are pulses and return to 0 by default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lat_cnt    <= 2'd0;
      lat_we     <= 1'b0;
      owner      <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      bank_sel   <= 2'd0;
      bank_en    <= 3'b000;
      bank_we    <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      bank_en <= 3'b000;
      bank_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            state      <= S_ISSUE;
            owner      <= win1;
            gnt0       <= ~win1;
            gnt1       <= win1;
            lat_we     <= pick_we;
            bank_sel   <= pick_bank;
            bank_en    <= pick_en;
            bank_we    <= pick_we & (pick_bank != 2'b11);
            bank_addr  <= pick_addr[ADDR_W-3:0];
            bank_wdata <= pick_wdata;
          end
        end
        S_ISSUE: begin
          if (bank_sel == 2'b11 || lat_we) begin
            // Writes and invalid-bank accesses complete without waiting.
            state <= S_RESP;
            done0 <= ~owner;
            done1 <= owner;
            err   <= (bank_sel == 2'b11);
          end else begin
            state   <= S_WAIT;
            lat_cnt <= LAT_M1;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 2'd0) begin
            state <= S_RESP;
            rdata <= rd_mux;
            done0 <= ~owner;
            done1 <= owner;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: begin  // S_RESP
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_bank_scheduler.md
Name: mem_bank_scheduler

Overview:
- Arbitrates two requesters (port 0: CPU load/store unit; port 1: program/data loader) for a three-bank data memory.
- Decodes the top two address bits into a one-hot bank enable. Returns read data and a completion pulse to the winning requester.
- Sequences one access at a time through a small FSM.
- Replaces free-running combinational bank routing with registered, glitch-free bank control.

Parameters:
- DATA_W, 16, data width of requester and bank buses.
- ADDR_W, 16, requester address width; addr[ADDR_W-1:ADDR_W-2] is the bank index, addr[ADDR_W-3:0] is the in-bank word address.
- READ_LAT, 1, cycles from the bank_en cycle to valid bank_rdataN; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held high until gnt0.
- we0  in  1  port 0 write (1) / read (0); valid while req0.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 request accepted (1-cycle pulse).
- done0  out  1  port 0 access complete (1-cycle pulse).
- req1, we1, addr1, wdata1, gnt1, done1: same as port 0, for port 1.
- rdata  out  DATA_W  read data of the last completed read; valid with done0/done1.
- err  out  1  invalid bank (index 2'b11); asserted with done.
- bank_sel  out  2  registered bank index of the current access.
- bank_en  out  3  one-hot bank enable; bit N selects bank N.
- bank_we  out  1  write strobe, qualified by bank_en.
- bank_addr  out  ADDR_W-2  in-bank address.
- bank_wdata  out  DATA_W  write data to banks.
- bank_rdata0, bank_rdata1, bank_rdata2  in  DATA_W  bank read data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including rdata.
  - Round-robin pointer last=1, so port 0 wins the first tie.
  - Any in-flight access is aborted; no done is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On a clock edge with req0 or req1 high, pick a winner and latch its we, addr and wdata.
  - Set bank_sel to the address top bits. Go to ISSUE.
  - Otherwise stay in IDLE with all strobes low.
- Arbitration:
  - Only one requester asserting: that requester wins.
  - Both asserting: the port opposite to last wins.
  - last updates to the winner on every grant.
- ISSUE (exactly 1 cycle):
  - gntW = 1 for the winner W.
  - bank_en = one-hot(bank_sel) and bank_we = latched we. bank_addr and bank_wdata are driven from latched values.
  - If bank_sel = 2'b11: bank_en = 0, bank_we = 0; next state is RESP with the error flag set.
  - Else if write: next state is RESP.
  - Else (read): next state is WAIT.
- WAIT (READ_LAT cycles):
  - bank_en = 0; a down-counter counts READ_LAT.
  - On the closing edge of the last WAIT cycle, rdata <= bank_rdata[bank_sel]. Go to RESP.
- RESP (1 cycle):
  - doneW = 1.
  - err = 1 only for an invalid bank.
  - Next state is IDLE.
- rdata holds its value until the next successful read completes. Writes and error accesses leave it unchanged.
- Latency, with a request seen at cycle 0:
  - Write: gnt/bank_en in cycle 1, done in cycle 2.
  - Read: gnt/bank_en in cycle 1, done in cycle 2+READ_LAT.
  - A new grant is possible at the earliest in the cycle after RESP+1, i.e. the IDLE sampling edge.
- A requester still asserting req after its done is treated as a new request.
- The losing requester keeps req high and is served next. No starvation under round-robin.
- Requester input changes after gnt are ignored (values are latched in IDLE).
- bank_en is never multi-hot; gnt0 and gnt1 are never both high.

Optional Feature:
- Macro MEM_SCHED_FIXED_PRIO_EN.
- Defined: port 0 always wins simultaneous requests. The last pointer is not implemented.
- Undefined (default): round-robin arbitration as above.

Test Plan:
- Reset, then port 0 write addr0=16'h4005, wdata0=16'hBEEF -> cycle 1: gnt0=1, bank_en=3'b010, bank_we=1, bank_addr=14'h0005, bank_wdata=16'hBEEF; cycle 2: done0=1, err=0.
- Port 1 read addr1=16'h8003 with bank_rdata2=16'h1234, READ_LAT=1 -> bank_en=3'b100, bank_we=0 in cycle 1; done1=1 and rdata=16'h1234 in cycle 3.
- req0 and req1 asserted together for 4 consecutive accesses -> grants alternate 0,1,0,1 (round-robin); all grants go to 0 when MEM_SCHED_FIXED_PRIO_EN is defined.
- Port 0 read addr0=16'hC000 -> bank_en stays 3'b000, done0=1 with err=1, rdata keeps its previous value.
- READ_LAT=3 read of bank 0 -> done0 exactly 5 cycles after the request; rdata equals bank_rdata0 sampled in cycle 4.
- rst_n pulsed low during WAIT of a read -> outputs 0 immediately, no done pulse; the next request is served normally from IDLE.
